fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised operand-bypass scoreboard for the 5-stage pipeline, replacing the fixed two-level E-stage forward muxes. It tracks every in-flight register write from the integer ALU (1-cycle) and the multi-cycle FALU in an age-ordered slot pipeline. It resolves each issuing instruction's rs1/rs2 to the youngest matching producer, stalls issue when that producer's result is not yet available, and drives the W-stage write-back.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width (int and float files)
- FALU_LAT, 3, FALU latency in cycles (≥2); slot count DEPTH = FALU_LAT+1
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- iss_valid  in  1  instruction issuing D→E this cycle
- iss_we / iss_rd / iss_is_f  in  1 / REG_AW / 1  writes a register / destination / destination is float file
- iss_rs1_en, iss_rs2_en  in  1 each  source used
- iss_rs1, iss_rs2  in  REG_AW each  source addresses
- iss_rs1_f, iss_rs2_f  in  1 each  source is float file
- rf_rs1_data, rf_rs2_data  in  XLEN each  register-file read data
- flush  in  1  kill E-stage instruction (slot 0) and suppress this cycle's issue
- int_res_valid / int_res_data  in  1 / XLEN  ALU result for slot 0
- falu_res_valid / falu_res_data  in  1 / XLEN  FALU result for slot FALU_LAT-1
- rs1_fwd_data, rs2_fwd_data  out  XLEN each  resolved operands
- rs1_fwd_hit, rs2_fwd_hit  out  1 each  operand came from a slot
- stall  out  1  hold issue; bubble enters slot 0
- wb_valid / wb_rd / wb_is_f / wb_data  out  1 / REG_AW / 1 / XLEN  write-back from slot DEPTH-1
- err  out  1  sticky protocol error

## Operation
- Slot k holds {valid, rd, is_f, ready, data}. Every cycle all slots shift k→k+1 unconditionally. Slot DEPTH-1 retires.
- Slot 0 loads an entry when iss_valid & iss_we & !stall & !flush: ready=0, data=0. Otherwise slot 0 loads a bubble (valid=0).
- int_res_valid writes data and ready=1 into the entry as it shifts out of slot 0. Requires slot 0 valid & !is_f.
- falu_res_valid does the same for slot FALU_LAT-1. Requires that slot to be valid & is_f.
- A result write to a mismatched or empty slot is ignored and sets err.
- flush invalidates slot 0 at the edge. flush has priority over result writes to slot 0.
- Match rule: slot valid, rd==rs, is_f==rs_f, source enabled. Integer rd==0 never matches; float f0 does match.
- Resolution per source takes the youngest match, i.e. the lowest k:
  - If the match is slot 0 with int_res_valid: forward int_res_data combinationally.
  - If the match is slot FALU_LAT-1 with falu_res_valid: forward falu_res_data combinationally.
  - Otherwise, if the slot is ready: forward its registered data.
  - Otherwise: not available.
- hit=1 on any match. With no match, data = rf data and hit=0.
- stall = iss_valid & (rs1 not available | rs2 not available). A stall decision never looks past the youngest match to older ready entries.
- wb_* mirror slot DEPTH-1. wb_valid=1 with ready=0 sets err; that entry is still presented.

## Timing
- Issue accepted in cycle t: the entry is in slot k during cycle t+1+k, and wb_valid is asserted in cycle t+DEPTH.
- Int producer → consumer issued in cycle t+1 sees a same-cycle bypass with no stall.
- FALU producer → consumer stalls cycles t+1 … t+FALU_LAT-1 and resolves in t+FALU_LAT.
- stall, fwd_data and fwd_hit are combinational. wb_* and err come from registers only.
- Reset (synchronous): all slots invalid, ready=0, data=0, err=0. Consequently wb_valid=0, wb_rd=0, wb_is_f=0, wb_data=0, and stall=0 (no matches).
- Reset asserted mid-operation discards all in-flight entries with no write-back.
- rst overrides flush and issue in the same cycle.
- err clears only on rst.
- Simultaneous int_res_valid, falu_res_valid and issue are independent and all take effect.

## Test plan
- rst held 2 cycles with iss_valid=1, iss_we=1 → no write-back ever appears; stall=0, err=0, wb_valid=0.
- Issue int x5 at t. Issue rs1=x5 at t+1 with int_res_valid and 0x00001234 → rs1_fwd_hit=1, rs1_fwd_data=0x00001234, stall=0. Write-back x5=0x1234 in cycle t+4 (FALU_LAT=3).
- Issue FALU f3 at t. Consumer on rs1=f3 → stall=1 in t+1 and t+2. At t+3, falu_res_valid with 0x3F800000 → forwarded, stall=0.
- Int write to x0, then read rs1=x0 with rf_rs1_data=0 → hit=0, data=0. Float f0 write then read f0 → hit=1.
- x7←0x0000000A then x7←0x0000000B on consecutive issues; reader at t+2 → 0x0000000B.
- Issue x9, then flush next cycle → no wb for x9. Then falu_res_valid with slot 2 empty → err=1, held until rst.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the issue stage, execution units and the operand-bypass scoreboard.
//   master : issue / execute side. Drives issue info, register-file read data, flush and
//            unit results; receives resolved operands, stall, write-back and err.
//   slave  : the scoreboard itself (reverse directions).
interface fwd_scoreboard_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              iss_valid;
  logic              iss_we;
  logic [REG_AW-1:0] iss_rd;
  logic              iss_is_f;
  logic              iss_rs1_en;
  logic              iss_rs2_en;
  logic [REG_AW-1:0] iss_rs1;
  logic [REG_AW-1:0] iss_rs2;
  logic              iss_rs1_f;
  logic              iss_rs2_f;
  logic [XLEN-1:0]   rf_rs1_data;
  logic [XLEN-1:0]   rf_rs2_data;
  logic              flush;
  logic              int_res_valid;
  logic [XLEN-1:0]   int_res_data;
  logic              falu_res_valid;
  logic [XLEN-1:0]   falu_res_data;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic [XLEN-1:0]   rs2_fwd_data;
  logic              rs1_fwd_hit;
  logic              rs2_fwd_hit;
  logic              stall;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_is_f;
  logic [XLEN-1:0]   wb_data;
  logic              err;

  modport master (
    output iss_valid, iss_we, iss_rd, iss_is_f, iss_rs1_en, iss_rs2_en, iss_rs1, iss_rs2,
           iss_rs1_f, iss_rs2_f, rf_rs1_data, rf_rs2_data, flush, int_res_valid,
           int_res_data, falu_res_valid, falu_res_data,
    input  rs1_fwd_data, rs2_fwd_data, rs1_fwd_hit, rs2_fwd_hit, stall, wb_valid, wb_rd,
           wb_is_f, wb_data, err
  );

  modport slave (
    input  iss_valid, iss_we, iss_rd, iss_is_f, iss_rs1_en, iss_rs2_en, iss_rs1, iss_rs2,
           iss_rs1_f, iss_rs2_f, rf_rs1_data, rf_rs2_data, flush, int_res_valid,
           int_res_data, falu_res_valid, falu_res_data,
    output rs1_fwd_data, rs2_fwd_data, rs1_fwd_hit, rs2_fwd_hit, stall, wb_valid, wb_rd,
           wb_is_f, wb_data, err
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-bypass scoreboard. Every in-flight register write occupies an age-ordered slot
// (slot 0 = youngest, E stage) that shifts one place per cycle and retires from slot
// DEPTH-1 as the W-stage write-back. Issuing sources resolve to the youngest matching slot.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fwd_scoreboard_if.slave (issue, rf data, flush, unit results in;
//              resolved operands, stall, write-back and sticky err out)
module fwd_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned FALU_LAT = 3
) (
  input logic             clk,
  input logic             rst,
  fwd_scoreboard_if.slave bus
);
  localparam int unsigned Depth    = FALU_LAT + 1;
  localparam int unsigned FaluSlot = FALU_LAT - 1;

  logic [Depth-1:0]  valid_q, valid_d;
  logic [Depth-1:0]  isf_q, isf_d;
  logic [Depth-1:0]  ready_q, ready_d;
  logic [REG_AW-1:0] rd_q   [Depth];
  logic [REG_AW-1:0] rd_d   [Depth];
  logic [XLEN-1:0]   data_q [Depth];
  logic [XLEN-1:0]   data_d [Depth];
  logic              err_q, err_d;

  logic            int_res_valid, falu_res_valid;
  logic [XLEN-1:0] int_res_data, falu_res_data;
  logic            int_target_ok, falu_target_ok;
  logic            accept, stall;
  logic [XLEN+1:0] res1, res2;

  assign int_res_valid  = bus.int_res_valid;
  assign int_res_data   = bus.int_res_data;
  assign falu_res_valid = bus.falu_res_valid;
  assign falu_res_data  = bus.falu_res_data;

  assign int_target_ok  = valid_q[0] & ~isf_q[0];
  assign falu_target_ok = valid_q[FaluSlot] & isf_q[FaluSlot];

  // Returns {avail, hit, data}. Walking from oldest to youngest lets the youngest match win;
  // older ready entries behind a not-ready youngest match are deliberately never used.
  function automatic logic [XLEN+1:0] resolve(input logic              en,
                                              input logic [REG_AW-1:0] rs,
                                              input logic              rs_f,
                                              input logic [XLEN-1:0]   rf);
    logic            hit;
    logic            avail;
    logic [XLEN-1:0] data;
    hit   = 1'b0;
    avail = 1'b1;
    data  = rf;
    for (int k = Depth - 1; k >= 0; k--) begin
      // Integer x0 is hard-wired zero and never a producer; float f0 is a real register.
      if (en && valid_q[k] && (rd_q[k] == rs) && (isf_q[k] == rs_f) &&
          (rs_f || (rs != '0))) begin
        hit = 1'b1;
        if ((k == 0) && int_res_valid) begin
          avail = 1'b1;
          data  = int_res_data;
        end else if ((k == int'(FaluSlot)) && falu_res_valid) begin
          avail = 1'b1;
          data  = falu_res_data;
        end else if (ready_q[k]) begin
          avail = 1'b1;
          data  = data_q[k];
        end else begin
          avail = 1'b0;
          data  = data_q[k];
        end
      end
    end
    return {avail, hit, data};
  endfunction

  always_comb begin
    res1  = resolve(bus.iss_rs1_en, bus.iss_rs1, bus.iss_rs1_f, bus.rf_rs1_data);
    res2  = resolve(bus.iss_rs2_en, bus.iss_rs2, bus.iss_rs2_f, bus.rf_rs2_data);
    stall = bus.iss_valid & ~(res1[XLEN+1] & res2[XLEN+1]);
  end

  assign bus.rs1_fwd_data = res1[XLEN-1:0];
  assign bus.rs1_fwd_hit  = res1[XLEN];
  assign bus.rs2_fwd_data = res2[XLEN-1:0];
  assign bus.rs2_fwd_hit  = res2[XLEN];
  assign bus.stall        = stall;

  assign accept = bus.iss_valid & bus.iss_we & ~stall & ~bus.flush;

  always_comb begin
    valid_d   = '0;
    isf_d     = '0;
    ready_d   = '0;
    rd_d[0]   = '0;
    data_d[0] = '0;
    // Slot 0 takes the newly accepted producer or a bubble.
    valid_d[0] = accept;
    isf_d[0]   = accept & bus.iss_is_f;
    if (accept) begin
      rd_d[0] = bus.iss_rd;
    end
    for (int k = 1; k < int'(Depth); k++) begin
      valid_d[k] = valid_q[k-1];
      isf_d[k]   = isf_q[k-1];
      ready_d[k] = ready_q[k-1];
      rd_d[k]    = rd_q[k-1];
      data_d[k]  = data_q[k-1];
    end
    // A flushed E-stage entry dies on its way out, taking any same-cycle ALU result with it.
    if (bus.flush) begin
      valid_d[1] = 1'b0;
    end else if (int_res_valid && int_target_ok) begin
      ready_d[1] = 1'b1;
      data_d[1]  = int_res_data;
    end
    if (falu_res_valid && falu_target_ok) begin
      ready_d[FaluSlot+1] = 1'b1;
      data_d[FaluSlot+1]  = falu_res_data;
    end
    err_d = err_q
          | (int_res_valid & ~int_target_ok)
          | (falu_res_valid & ~falu_target_ok)
          | (valid_q[Depth-1] & ~ready_q[Depth-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      isf_q   <= '0;
      ready_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < int'(Depth); k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      isf_q   <= isf_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      for (int k = 0; k < int'(Depth); k++) begin
        rd_q[k]   <= rd_d[k];
        data_q[k] <= data_d[k];
      end
    end
  end

  assign bus.wb_valid = valid_q[Depth-1];
  assign bus.wb_rd    = rd_q[Depth-1];
  assign bus.wb_is_f  = isf_q[Depth-1];
  assign bus.wb_data  = data_q[Depth-1];
  assign bus.err      = err_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FALU_LAT = 3;
  localparam int          DEPTH    = FALU_LAT + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  fwd_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .FALU_LAT(FALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        is_f;
    int          age;
    logic        ready;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_we = 0; bus.iss_rd = '0; bus.iss_is_f = 0;
    bus.iss_rs1_en = 0; bus.iss_rs2_en = 0; bus.iss_rs1 = '0; bus.iss_rs2 = '0;
    bus.iss_rs1_f = 0; bus.iss_rs2_f = 0; bus.rf_rs1_data = '0; bus.rf_rs2_data = '0;
    bus.flush = 0; bus.int_res_valid = 0; bus.int_res_data = '0;
    bus.falu_res_valid = 0; bus.falu_res_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic is_f);
    bus.iss_valid = 1; bus.iss_we = 1; bus.iss_rd = rd; bus.iss_is_f = is_f;
  endtask

  task automatic read1(input logic [4:0] rs, input logic rs_f, input logic [31:0] rf);
    bus.iss_valid = 1; bus.iss_rs1_en = 1; bus.iss_rs1 = rs; bus.iss_rs1_f = rs_f;
    bus.rf_rs1_data = rf;
  endtask

  // Spec-level lookup: youngest live producer of (rs, rs_f) and whether its value exists yet.
  function automatic void ref_resolve(input logic en, input logic [4:0] rs, input logic rs_f,
                                      input logic [31:0] rf, input logic iv,
                                      input logic [31:0] id, input logic fv,
                                      input logic [31:0] fd, output logic hit,
                                      output logic avail, output logic [31:0] data);
    int best;
    best  = -1;
    hit   = 0;
    avail = 1;
    data  = rf;
    if (!en || (!rs_f && rs == 0)) return;
    foreach (q[i]) begin
      if (q[i].rd == rs && q[i].is_f == rs_f && (best < 0 || q[i].age < q[best].age)) best = i;
    end
    if (best < 0) return;
    hit = 1;
    if (q[best].age == 0 && iv) data = id;
    else if (q[best].age == int'(FALU_LAT) - 1 && fv) data = fd;
    else if (q[best].ready) data = q[best].data;
    else avail = 0;
  endfunction

  initial begin
    logic        iv, fv, h1, h2, a1, a2, stall_exp, accept, wbv;
    logic [31:0] d1, d2;
    ent_t        nq[$];
    ent_t        e, wbe;

    idle();
    // Reset held two cycles while an issue is presented: nothing may enter the pipeline.
    rst = 1;
    issue(5'd4, 0);
    tick();
    check("rst_stall", bus.stall, 0);
    check("rst_err", bus.err, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    check("rst_wb_is_f", bus.wb_is_f, 0);
    check("rst_wb_data", bus.wb_data, 0);
    tick();
    rst = 0;
    idle();
    for (int i = 0; i < DEPTH + 2; i++) begin
      #1 check("post_rst_no_wb", bus.wb_valid, 0);
      tick();
    end

    // Int producer x5, same-cycle bypass to the next instruction, write-back at t+4.
    issue(5'd5, 0);
    tick();
    idle();
    read1(5'd5, 0, 32'hFFFF_0000);
    bus.int_res_valid = 1; bus.int_res_data = 32'h0000_1234;
    #1;
    check("int_byp_hit", bus.rs1_fwd_hit, 1);
    check("int_byp_data", bus.rs1_fwd_data, 32'h0000_1234);
    check("int_byp_stall", bus.stall, 0);
    tick();
    idle();
    tick();
    check("int_wb_early", bus.wb_valid, 0);
    tick();
    check("int_wb_valid", bus.wb_valid, 1);
    check("int_wb_rd", bus.wb_rd, 5);
    check("int_wb_is_f", bus.wb_is_f, 0);
    check("int_wb_data", bus.wb_data, 32'h0000_1234);
    tick();

    // FALU producer f3: consumer stalls two cycles, resolves when the result appears.
    issue(5'd3, 1);
    tick();
    idle();
    read1(5'd3, 1, 32'h0);
    #1 check("falu_stall_t1", bus.stall, 1);
    tick();
    #1 check("falu_stall_t2", bus.stall, 1);
    tick();
    bus.falu_res_valid = 1; bus.falu_res_data = 32'h3F80_0000;
    #1;
    check("falu_fwd_stall", bus.stall, 0);
    check("falu_fwd_hit", bus.rs1_fwd_hit, 1);
    check("falu_fwd_data", bus.rs1_fwd_data, 32'h3F80_0000);
    tick();
    idle();
    check("falu_wb_valid", bus.wb_valid, 1);
    check("falu_wb_is_f", bus.wb_is_f, 1);
    check("falu_wb_data", bus.wb_data, 32'h3F80_0000);
    tick();

    // x0 never matches; f0 does.
    issue(5'd0, 0);
    tick();
    idle();
    read1(5'd0, 0, 32'h0);
    bus.int_res_valid = 1; bus.int_res_data = 32'h0000_DEAD;
    #1;
    check("x0_hit", bus.rs1_fwd_hit, 0);
    check("x0_data", bus.rs1_fwd_data, 0);
    check("x0_stall", bus.stall, 0);
    tick();
    idle();
    issue(5'd0, 1);
    tick();
    idle();
    read1(5'd0, 1, 32'h1111_1111);
    #1;
    check("f0_hit", bus.rs1_fwd_hit, 1);
    check("f0_stall", bus.stall, 1);
    tick();
    idle();
    tick();
    bus.falu_res_valid = 1; bus.falu_res_data = 32'h4000_0000;
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++) tick();

    // Back-to-back x7 writes: the reader sees the younger one; unmatched rs2 reads the rf.
    issue(5'd7, 0);
    tick();
    bus.int_res_valid = 1; bus.int_res_data = 32'h0000_000A;
    tick();
    idle();
    read1(5'd7, 0, 32'h0);
    bus.iss_rs2_en = 1; bus.iss_rs2 = 5'd9; bus.rf_rs2_data = 32'h0000_0055;
    bus.int_res_valid = 1; bus.int_res_data = 32'h0000_000B;
    #1;
    check("x7_young_data", bus.rs1_fwd_data, 32'h0000_000B);
    check("x7_young_hit", bus.rs1_fwd_hit, 1);
    check("rs2_rf_hit", bus.rs2_fwd_hit, 0);
    check("rs2_rf_data", bus.rs2_fwd_data, 32'h0000_0055);
    check("x7_stall", bus.stall, 0);
    tick();
    idle();
    for (int i = 0; i < DEPTH; i++) tick();
    check("directed_err", bus.err, 0);

    // Randomised traffic against the queue model; protocol-correct results only.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.iss_valid   = 1'($urandom_range(0, 1));
      bus.iss_we      = 1'($urandom_range(0, 1));
      bus.iss_rd      = 5'($urandom_range(0, 3));
      bus.iss_is_f    = 1'($urandom_range(0, 1));
      bus.iss_rs1_en  = 1'($urandom_range(0, 1));
      bus.iss_rs2_en  = 1'($urandom_range(0, 1));
      bus.iss_rs1     = 5'($urandom_range(0, 3));
      bus.iss_rs2     = 5'($urandom_range(0, 3));
      bus.iss_rs1_f   = 1'($urandom_range(0, 1));
      bus.iss_rs2_f   = 1'($urandom_range(0, 1));
      bus.rf_rs1_data = $urandom;
      bus.rf_rs2_data = $urandom;
      bus.flush       = ($urandom_range(0, 9) == 0);
      iv = 0;
      fv = 0;
      wbv = 0;
      foreach (q[i]) begin
        if (q[i].age == 0 && !q[i].is_f && !bus.flush) iv = 1;
        if (q[i].age == int'(FALU_LAT) - 1 && q[i].is_f) fv = 1;
        if (q[i].age == DEPTH - 1) begin
          wbv = 1;
          wbe = q[i];
        end
      end
      bus.int_res_valid  = iv;
      bus.int_res_data   = $urandom;
      bus.falu_res_valid = fv;
      bus.falu_res_data  = $urandom;
      ref_resolve(bus.iss_rs1_en, bus.iss_rs1, bus.iss_rs1_f, bus.rf_rs1_data, iv,
                  bus.int_res_data, fv, bus.falu_res_data, h1, a1, d1);
      ref_resolve(bus.iss_rs2_en, bus.iss_rs2, bus.iss_rs2_f, bus.rf_rs2_data, iv,
                  bus.int_res_data, fv, bus.falu_res_data, h2, a2, d2);
      stall_exp = bus.iss_valid & !(a1 & a2);
      #1;
      check("rnd_stall", bus.stall, stall_exp);
      check("rnd_rs1_hit", bus.rs1_fwd_hit, h1);
      check("rnd_rs2_hit", bus.rs2_fwd_hit, h2);
      if (a1) check("rnd_rs1_data", bus.rs1_fwd_data, d1);
      if (a2) check("rnd_rs2_data", bus.rs2_fwd_data, d2);
      check("rnd_wb_valid", bus.wb_valid, wbv);
      if (wbv) begin
        check("rnd_wb_rd", bus.wb_rd, wbe.rd);
        check("rnd_wb_is_f", bus.wb_is_f, wbe.is_f);
        check("rnd_wb_data", bus.wb_data, wbe.data);
      end
      check("rnd_err", bus.err, 0);
      accept = bus.iss_valid & bus.iss_we & !stall_exp & !bus.flush;
      @(posedge clk);
      nq = {};
      foreach (q[i]) begin
        e = q[i];
        if (e.age == 0 && iv) begin
          e.ready = 1;
          e.data  = bus.int_res_data;
        end
        if (e.age == int'(FALU_LAT) - 1 && fv) begin
          e.ready = 1;
          e.data  = bus.falu_res_data;
        end
        if (!(bus.flush && e.age == 0)) begin
          e.age++;
          if (e.age < DEPTH) nq.push_back(e);
        end
      end
      if (accept) begin
        e.rd    = bus.iss_rd;
        e.is_f  = bus.iss_is_f;
        e.age   = 0;
        e.ready = 0;
        e.data  = '0;
        nq.push_back(e);
      end
      q = nq;
      #1;
    end

    // Reset mid-flight with a fresh issue in flight: nothing may write back afterwards.
    idle();
    issue(5'd6, 0);
    tick();
    idle();
    rst = 1;
    issue(5'd8, 0);
    tick();
    rst = 0;
    idle();
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1 check("midrst_no_wb", bus.wb_valid, 0);
      tick();
    end

    // Flush kills x9 (and its same-cycle ALU result) and suppresses the issue of x10.
    issue(5'd9, 0);
    tick();
    idle();
    issue(5'd10, 0);
    bus.flush = 1;
    bus.int_res_valid = 1; bus.int_res_data = 32'h0000_0099;
    tick();
    idle();
    for (int i = 0; i < DEPTH + 1; i++) begin
      #1 check("flush_no_wb", bus.wb_valid, 0);
      tick();
    end
    check("flush_err", bus.err, 0);
    // FALU result into an empty slot: sticky error until reset.
    bus.falu_res_valid = 1; bus.falu_res_data = 32'h1234_5678;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      check("err_sticky", bus.err, 1);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    check("err_cleared", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
